writeback_unit: RTL and testbench

- Producer side of the register file write port. Merges results from the ALU path and the load path into the single write port: register_write, write_data, register_write_enable.
- ALU results are buffered in a small FIFO. Load results have strict priority.
- Keeps a per-register pending scoreboard so decode can detect read-after-write hazards on rs_1/rs_2.

---
 rtl/writeback_unit.sv | 75 +++++++
 tb/tb_writeback_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges load and buffered ALU results onto the register write port and tracks pending destinations
module writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [4:0]                        alu_rd,
  input  logic [31:0]                       alu_result,
  input  logic                              load_valid,
  input  logic [4:0]                        load_rd,
  input  logic [31:0]                       load_data,
  input  logic                              issue_valid,
  input  logic [4:0]                        issue_rd,
  input  logic [4:0]                        rs_1,
  input  logic [4:0]                        rs_2,
  output logic                              rs1_pending,
  output logic                              rs2_pending,
  output logic [4:0]                        register_write,
  output logic [31:0]                       write_data,
  output logic                              register_write_enable,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [4:0]          fifo_rd [FIFO_DEPTH];
  logic [31:0]         fifo_data [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop, sel_valid, write;
  logic [4:0]          sel_rd;
  logic [31:0]         sel_data;
  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  always_comb begin
    alu_ready = fifo_count != CW'(FIFO_DEPTH);
    push = alu_valid && alu_ready;
    pop = !load_valid && fifo_count != '0;
    sel_valid = load_valid || pop;
    sel_rd = load_valid ? load_rd : fifo_rd[rd_ptr];
    sel_data = load_valid ? load_data : fifo_data[rd_ptr];
    write = sel_valid && sel_rd != '0;
    set_mask = (issue_valid && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
    clr_mask = register_write_enable ? NUM_REGS'(1) << register_write : '0;
    rs1_pending = pending[rs_1];
    rs2_pending = pending[rs_2];
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_rd[wr_ptr] <= alu_rd;
      fifo_data[wr_ptr] <= alu_result;
    end
  // set is applied after clear so a same-edge re-issue keeps the bit
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      pending <= '0;
      register_write_enable <= 1'b0;
      register_write <= '0;
      write_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      pending <= (pending & ~clr_mask) | set_mask;
      register_write_enable <= write;
      if (write) begin
        register_write <= sel_rd;
        write_data <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven and sequence checks with an expected-write queue
module tb_writeback_unit;
  logic clk = 0, reset = 1;
  logic alu_valid = 0, load_valid = 0, issue_valid = 0;
  logic alu_ready, rs1_pending, rs2_pending, register_write_enable;
  logic [4:0] alu_rd = 0, load_rd = 0, issue_rd = 0, rs_1 = 0, rs_2 = 0, register_write;
  logic [31:0] alu_result = 0, load_data = 0, write_data;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  typedef struct {logic is_load; logic [4:0] rd; logic [31:0] data; int lat;} vec_t;
  typedef struct {logic [4:0] rd; logic [31:0] data;} wr_t;
  vec_t vecs[6];
  wr_t exp_q[$];
  always #5 clk = ~clk;
  writeback_unit dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_result(alu_result), .load_valid(load_valid),
    .load_rd(load_rd), .load_data(load_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .rs_1(rs_1), .rs_2(rs_2), .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending), .register_write(register_write),
    .write_data(write_data), .register_write_enable(register_write_enable),
    .fifo_count(fifo_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask
  always @(negedge clk)
    if (register_write_enable) begin
      wr_t w;
      if (exp_q.size() == 0) chk("unexpected_write", {27'd0, register_write}, 32'hFFFF_FFFF);
      else begin
        w = exp_q.pop_front();
        chk("sb_rd", {27'd0, register_write}, {27'd0, w.rd});
        chk("sb_data", write_data, w.data);
      end
    end
  initial begin
    vecs[0] = '{1'b1, 5'd1,  32'h1111_0001, 1};
    vecs[1] = '{1'b0, 5'd5,  32'hDEAD_BEEF, 2};
    vecs[2] = '{1'b1, 5'd0,  32'h0BAD_0000, 1};
    vecs[3] = '{1'b0, 5'd0,  32'h0BAD_0001, 2};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1};
    vecs[5] = '{1'b0, 5'd31, 32'h0000_0000, 2};
    tick;
    tick;
    reset = 0;
    chk("rst_en", {31'd0, register_write_enable}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ready", {31'd0, alu_ready}, 1);
    chk("rst_wr_idx", {27'd0, register_write}, 0);
    chk("rst_wr_data", write_data, 0);
    for (int r = 0; r < 32; r++) begin
      rs_1 = 5'(r);
      rs_2 = 5'(31 - r);
      #1;
      chk("rst_rs1_pending", {31'd0, rs1_pending}, 0);
      chk("rst_rs2_pending", {31'd0, rs2_pending}, 0);
    end
    for (int i = 0; i < 6; i++) begin
      load_valid = vecs[i].is_load;
      alu_valid = !vecs[i].is_load;
      load_rd = vecs[i].rd;
      alu_rd = vecs[i].rd;
      load_data = vecs[i].data;
      alu_result = vecs[i].data;
      if (vecs[i].rd != 0) expect_wr(vecs[i].rd, vecs[i].data);
      tick;
      load_valid = 0;
      alu_valid = 0;
      for (int c = 1; c <= 3; c++) begin
        chk("vec_en", {31'd0, register_write_enable}, {31'd0, c == vecs[i].lat && vecs[i].rd != 0});
        if (c == vecs[i].lat && vecs[i].rd != 0) chk("vec_idx", {27'd0, register_write}, {27'd0, vecs[i].rd});
        tick;
      end
      chk("vec_count", {29'd0, fifo_count}, 0);
    end
    load_valid = 1; load_rd = 3; load_data = 32'h11;
    alu_valid = 1; alu_rd = 4; alu_result = 32'h22;
    expect_wr(3, 32'h11);
    expect_wr(4, 32'h22);
    tick;
    load_valid = 0; alu_valid = 0;
    chk("col_en1", {31'd0, register_write_enable}, 1);
    chk("col_idx1", {27'd0, register_write}, 3);
    tick;
    chk("col_en2", {31'd0, register_write_enable}, 1);
    chk("col_data2", write_data, 32'h22);
    tick;
    chk("col_idle", {31'd0, register_write_enable}, 0);
    load_valid = 1; load_rd = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_result = 32'hA0 + 32'(i);
      expect_wr(5'(10 + i), 32'hA0 + 32'(i));
      tick;
    end
    alu_rd = 20; alu_result = 32'hBAD;
    chk("full_count", {29'd0, fifo_count}, 4);
    chk("full_ready", {31'd0, alu_ready}, 0);
    tick;
    alu_valid = 0;
    chk("full_hold_count", {29'd0, fifo_count}, 4);
    chk("full_hold_en", {31'd0, register_write_enable}, 0);
    load_valid = 0;
    tick;
    chk("drain_ready", {31'd0, alu_ready}, 1);
    chk("drain_count", {29'd0, fifo_count}, 3);
    for (int i = 0; i < 4; i++) begin
      chk("drain_en", {31'd0, register_write_enable}, 1);
      chk("drain_idx", {27'd0, register_write}, 32'(10 + i));
      tick;
    end
    chk("drain_idle", {31'd0, register_write_enable}, 0);
    chk("drain_empty", {29'd0, fifo_count}, 0);
    rs_1 = 7; rs_2 = 7;
    issue_valid = 1; issue_rd = 7;
    tick;
    issue_valid = 0;
    chk("sb_set", {31'd0, rs1_pending}, 1);
    chk("sb_set_rs2", {31'd0, rs2_pending}, 1);
    tick;
    tick;
    load_valid = 1; load_rd = 7; load_data = 32'h77;
    expect_wr(7, 32'h77);
    tick;
    load_valid = 0;
    chk("sb_write_cycle", {31'd0, rs1_pending}, 1);
    tick;
    chk("sb_cleared", {31'd0, rs1_pending}, 0);
    issue_valid = 1;
    tick;
    issue_valid = 0;
    load_valid = 1; load_data = 32'h78;
    expect_wr(7, 32'h78);
    tick;
    load_valid = 0;
    issue_valid = 1;
    tick;
    issue_valid = 0;
    chk("sb_set_wins", {31'd0, rs1_pending}, 1);
    tick;
    chk("sb_set_holds", {31'd0, rs1_pending}, 1);
    issue_valid = 1; issue_rd = 0; rs_1 = 0;
    tick;
    issue_valid = 0;
    chk("sb_x0", {31'd0, rs1_pending}, 0);
    load_valid = 1; load_rd = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_result = 32'hC0 + 32'(i);
      issue_valid = 1; issue_rd = 9;
      tick;
    end
    alu_valid = 0; issue_valid = 0;
    chk("pre_rst_count", {29'd0, fifo_count}, 3);
    load_valid = 0;
    reset = 1;
    tick;
    reset = 0;
    rs_1 = 9; rs_2 = 7;
    #1;
    chk("mid_rst_count", {29'd0, fifo_count}, 0);
    chk("mid_rst_en", {31'd0, register_write_enable}, 0);
    chk("mid_rst_rs1", {31'd0, rs1_pending}, 0);
    chk("mid_rst_rs2", {31'd0, rs2_pending}, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("post_rst_en", {31'd0, register_write_enable}, 0);
    end
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
